pcie_symbol_framer: RTL and testbench
=====================================

// Module: pcie_symbol_framer
// PURPOSE
// - Registered, multi-lane successor to the single-byte special-symbol classifier. Classifies every lane byte into a
//   4-bit symbol code and runs a framing FSM across lanes (lane 0 first) and across cycles.
// - Reports packet start/end, TLP/DLLP type, payload length, END/EDB status and framing errors.
// - Sits between lane deskew and the data-link receive logic.
// PARAMETERS
// - LANES   4    lanes per beat; legal values 1,2,4,8
// - LEN_W   12   payload-length counter width
// PORTS
// - clk        in   1          rising-edge clock
// - reset      in   1          synchronous, active-high reset
// - valid_in   in   1          beat qualifier
// - data_in    in   LANES*8    lane i = bits [8i+7:8i]
// - valid_out  out  1          registered valid_in
// - data_out   out  LANES*8    data_in delayed one cycle
// - code_out   out  LANES*4    per-lane code: 0 data, 1 COM(BC), 2 PAD(F7), 3 SKP(1C), 4 STP(FB), 5 SDP(5C),
//                              6 END(FD), 7 EDB(FE), 8 FTS(3C), 9 IDL(7C)
// - pkt_dat    out  LANES      lane byte is payload inside a packet
// - sop        out  LANES      lane holds the STP/SDP that opened a packet
// - eop        out  LANES      lane holds the END/EDB that closed a packet
// - pkt_done   out  1          packet completed this beat
// - pkt_type   out  1          0 TLP (STP), 1 DLLP (SDP); valid with pkt_done
// - pkt_good   out  1          1 END, 0 EDB (nullified); valid with pkt_done
// - pkt_len    out  LEN_W      payload byte count, excluding framing symbols; valid with pkt_done
// - frame_err  out  1          one-cycle pulse: framing error anywhere in the beat
// BEHAVIOUR
// - Clock and reset: one clock, clk. Reset is synchronous and active-high on reset.
// - Reset: every output is 0; FSM goes to IDLE; length counter is 0.
//   Reset mid-packet discards the packet with no pkt_done.
// - Latency: all outputs are registered, 1 cycle after the beat.
// - valid_in=0: FSM and length counter hold. Next cycle, all outputs are 0 except data_out, which is don't-care.
// - FSM states: IDLE, TLP, DLLP. Scan lanes 0..LANES-1 sequentially within a beat; state carries lane to lane.
// - IDLE:
//   - STP -> TLP, SDP -> DLLP. Set sop[i] and clear the counter.
//   - COM/PAD/SKP/FTS/IDL/data: stay in IDLE, no flag.
//   - END/EDB: frame_err, stay in IDLE.
// - TLP/DLLP:
//   - data: pkt_dat[i]=1 and length+1. Length saturates at 2^LEN_W-1 and holds.
//   - END/EDB: eop[i], pkt_done, pkt_good=(END), pkt_len=count, pkt_type=state; then -> IDLE.
//   - STP/SDP: frame_err, abort the open packet (no pkt_done), then open the new packet on this lane (sop[i]).
//   - COM/PAD/SKP/FTS/IDL: frame_err, abort, -> IDLE.
// - Packets span any number of beats; state and count persist across beats.
// - Minimum packet is 8 symbols, so LANES<=8 gives at most one pkt_done per beat.
//   Any further completion in the same beat is undefined and is not checked.
// - frame_err is a single bit: multiple errors in one beat give one pulse.
// - Packet start and end in the same beat: both sop and eop are set, and pkt_len counts only that beat's payload.
// CONFIGURATION
// - FRAMER_STATS_EN defined adds outputs cnt_good, cnt_null, cnt_err (16 bits each, out).
//   - Counters saturate at FFFF and are cleared by reset.
//   - Increment on pkt_done&pkt_good, pkt_done&!pkt_good and frame_err respectively, one cycle after the flag.
// - FRAMER_STATS_EN undefined: the ports and counters do not exist; all other behaviour is identical.
// TESTING
// - LANES=4: beat FB,00,01,02 then 03,04,05,FD -> sop=0001, then eop=1000, pkt_done, type 0, good 1, len 6.
// - SDP DLLP 5C + 6 data + FE -> pkt_done, type 1, good 0, len 6; pkt_dat set on the 6 data lanes only.
// - END (FD) in IDLE -> frame_err=1, pkt_done=0, code_out lane=6.
// - STP + 2 data, then beat BC,... -> frame_err, no pkt_done; a later FD -> frame_err only.
// - STP opened, valid_in=0 for 3 cycles, then 2 data + END -> len counts across the gap;
//   reset asserted mid-packet instead -> all outputs 0 and a later END gives frame_err.
// - FRAMER_STATS_EN: 2 good, 1 nullified, 3 errors -> cnt_good=2, cnt_null=1, cnt_err=3; force FFFF -> holds FFFF.

Source files
------------

// File: rtl/pcie_symbol_framer_if.sv
// Beat-level bus between lane deskew and the symbol framer.
// With FRAMER_STATS_EN defined the bus also carries the packet/error statistics counters.
interface pcie_symbol_framer_if #(
    parameter int LANES = 4,
    parameter int LEN_W = 12
);
    logic               valid_in;
    logic [LANES*8-1:0] data_in;
    logic               valid_out;
    logic [LANES*8-1:0] data_out;
    logic [LANES*4-1:0] code_out;
    logic [LANES-1:0]   pkt_dat;
    logic [LANES-1:0]   sop;
    logic [LANES-1:0]   eop;
    logic               pkt_done;
    logic               pkt_type;
    logic               pkt_good;
    logic [LEN_W-1:0]   pkt_len;
    logic               frame_err;
`ifdef FRAMER_STATS_EN
    logic [15:0]        cnt_good;
    logic [15:0]        cnt_null;
    logic [15:0]        cnt_err;

    modport master (
        output valid_in, data_in,
        input  valid_out, data_out, code_out, pkt_dat, sop, eop,
               pkt_done, pkt_type, pkt_good, pkt_len, frame_err,
               cnt_good, cnt_null, cnt_err
    );
    modport slave (
        input  valid_in, data_in,
        output valid_out, data_out, code_out, pkt_dat, sop, eop,
               pkt_done, pkt_type, pkt_good, pkt_len, frame_err,
               cnt_good, cnt_null, cnt_err
    );
`else
    modport master (
        output valid_in, data_in,
        input  valid_out, data_out, code_out, pkt_dat, sop, eop,
               pkt_done, pkt_type, pkt_good, pkt_len, frame_err
    );
    modport slave (
        input  valid_in, data_in,
        output valid_out, data_out, code_out, pkt_dat, sop, eop,
               pkt_done, pkt_type, pkt_good, pkt_len, frame_err
    );
`endif
endinterface

// File: rtl/pcie_symbol_framer.sv
// Multi-lane PCIe special-symbol classifier and packet framer, one registered stage.
// Optional FRAMER_STATS_EN adds saturating good/nullified/error packet counters.
module pcie_symbol_framer #(
    parameter int LANES = 4,
    parameter int LEN_W = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    pcie_symbol_framer_if.slave   bus
);
    localparam logic [3:0] C_DAT = 4'd0, C_COM = 4'd1, C_PAD = 4'd2, C_SKP = 4'd3,
                           C_STP = 4'd4, C_SDP = 4'd5, C_END = 4'd6, C_EDB = 4'd7,
                           C_FTS = 4'd8, C_IDL = 4'd9;

    typedef enum logic [1:0] {S_IDLE, S_TLP, S_DLLP} state_t;

    function automatic logic [3:0] classify(input logic [7:0] b);
        case (b)
            8'hBC:   classify = C_COM;
            8'hF7:   classify = C_PAD;
            8'h1C:   classify = C_SKP;
            8'hFB:   classify = C_STP;
            8'h5C:   classify = C_SDP;
            8'hFD:   classify = C_END;
            8'hFE:   classify = C_EDB;
            8'h3C:   classify = C_FTS;
            8'h7C:   classify = C_IDL;
            default: classify = C_DAT;
        endcase
    endfunction

    function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] v);
        sat_inc = (v == {LEN_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    state_t             r_state, w_state_nxt;
    logic [LEN_W-1:0]   r_len, w_len_nxt;
    logic [LANES*4-1:0] w_code;
    logic [LANES-1:0]   w_pkt_dat, w_sop, w_eop;
    logic               w_done, w_type, w_good, w_err;
    logic [LEN_W-1:0]   w_len;

    logic               r_valid_p1, r_done_p1, r_type_p1, r_good_p1, r_err_p1;
    logic [LANES*8-1:0] r_data_p1;
    logic [LANES*4-1:0] r_code_p1;
    logic [LANES-1:0]   r_pkt_dat_p1, r_sop_p1, r_eop_p1;
    logic [LEN_W-1:0]   r_len_p1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_len   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_len   <= w_len_nxt;
        end
    end

    // Lane scan: state and length ripple from lane 0 upward within the beat.
    always_comb begin
        state_t           v_st;
        logic [LEN_W-1:0] v_len;
        logic [3:0]       v_c;
        w_state_nxt = r_state;
        w_len_nxt   = r_len;
        w_code      = '0;
        w_pkt_dat   = '0;
        w_sop       = '0;
        w_eop       = '0;
        w_done      = 1'b0;
        w_type      = 1'b0;
        w_good      = 1'b0;
        w_len       = '0;
        w_err       = 1'b0;
        v_st        = r_state;
        v_len       = r_len;
        for (int i = 0; i < LANES; i++) begin
            v_c = classify(bus.data_in[8*i +: 8]);
            w_code[4*i +: 4] = v_c;
            if (v_st == S_IDLE) begin
                if (v_c == C_STP || v_c == C_SDP) begin
                    v_st     = (v_c == C_STP) ? S_TLP : S_DLLP;
                    v_len    = '0;
                    w_sop[i] = 1'b1;
                end else if (v_c == C_END || v_c == C_EDB) begin
                    w_err = 1'b1;
                end
            end else begin
                if (v_c == C_DAT) begin
                    w_pkt_dat[i] = 1'b1;
                    v_len        = sat_inc(v_len);
                end else if (v_c == C_END || v_c == C_EDB) begin
                    w_eop[i] = 1'b1;
                    w_done   = 1'b1;
                    w_good   = (v_c == C_END);
                    w_type   = (v_st == S_DLLP);
                    w_len    = v_len;
                    v_st     = S_IDLE;
                end else if (v_c == C_STP || v_c == C_SDP) begin
                    // Abort the open packet and reopen on this lane.
                    w_err    = 1'b1;
                    w_sop[i] = 1'b1;
                    v_st     = (v_c == C_STP) ? S_TLP : S_DLLP;
                    v_len    = '0;
                end else begin
                    w_err = 1'b1;
                    v_st  = S_IDLE;
                end
            end
        end
        if (bus.valid_in) begin
            w_state_nxt = v_st;
            w_len_nxt   = v_len;
        end else begin
            w_code    = '0;
            w_pkt_dat = '0;
            w_sop     = '0;
            w_eop     = '0;
            w_done    = 1'b0;
            w_type    = 1'b0;
            w_good    = 1'b0;
            w_len     = '0;
            w_err     = 1'b0;
        end
    end

    // Output register stage (p1).
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid_p1   <= 1'b0;
            r_data_p1    <= '0;
            r_code_p1    <= '0;
            r_pkt_dat_p1 <= '0;
            r_sop_p1     <= '0;
            r_eop_p1     <= '0;
            r_done_p1    <= 1'b0;
            r_type_p1    <= 1'b0;
            r_good_p1    <= 1'b0;
            r_len_p1     <= '0;
            r_err_p1     <= 1'b0;
        end else begin
            r_valid_p1   <= bus.valid_in;
            r_data_p1    <= bus.data_in;
            r_code_p1    <= w_code;
            r_pkt_dat_p1 <= w_pkt_dat;
            r_sop_p1     <= w_sop;
            r_eop_p1     <= w_eop;
            r_done_p1    <= w_done;
            r_type_p1    <= w_type;
            r_good_p1    <= w_good;
            r_len_p1     <= w_len;
            r_err_p1     <= w_err;
        end
    end

    assign bus.valid_out = r_valid_p1;
    assign bus.data_out  = r_data_p1;
    assign bus.code_out  = r_code_p1;
    assign bus.pkt_dat   = r_pkt_dat_p1;
    assign bus.sop       = r_sop_p1;
    assign bus.eop       = r_eop_p1;
    assign bus.pkt_done  = r_done_p1;
    assign bus.pkt_type  = r_type_p1;
    assign bus.pkt_good  = r_good_p1;
    assign bus.pkt_len   = r_len_p1;
    assign bus.frame_err = r_err_p1;

`ifdef FRAMER_STATS_EN
    function automatic logic [15:0] sat16(input logic [15:0] v);
        sat16 = (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [15:0] r_cnt_good_p2, r_cnt_null_p2, r_cnt_err_p2;

    // Statistics stage (p2): counts the registered flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt_good_p2 <= '0;
            r_cnt_null_p2 <= '0;
            r_cnt_err_p2  <= '0;
        end else begin
            if (r_done_p1 && r_good_p1)  r_cnt_good_p2 <= sat16(r_cnt_good_p2);
            if (r_done_p1 && !r_good_p1) r_cnt_null_p2 <= sat16(r_cnt_null_p2);
            if (r_err_p1)                r_cnt_err_p2  <= sat16(r_cnt_err_p2);
        end
    end

    assign bus.cnt_good = r_cnt_good_p2;
    assign bus.cnt_null = r_cnt_null_p2;
    assign bus.cnt_err  = r_cnt_err_p2;
`endif
endmodule

// File: tb/tb_pcie_symbol_framer.sv
// Directed, table-driven bench for pcie_symbol_framer at LANES=4, LEN_W=12.
// Statistics counters are exercised when FRAMER_STATS_EN is defined.
module tb_pcie_symbol_framer;
    localparam int LANES = 4;
    localparam int LEN_W = 12;

    typedef struct {
        logic        vld;
        logic [31:0] din;
        logic [15:0] code;
        logic [3:0]  pdat;
        logic [3:0]  sop;
        logic [3:0]  eop;
        logic        done;
        logic        typ;
        logic        good;
        logic [11:0] len;
        logic        err;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_bad = 0;
    vec_t tbl[$];

    pcie_symbol_framer_if #(.LANES(LANES), .LEN_W(LEN_W)) bus ();

    pcie_symbol_framer #(.LANES(LANES), .LEN_W(LEN_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic vld, input logic [31:0] din, input logic [15:0] code,
                                input logic [3:0] pdat, input logic [3:0] sop, input logic [3:0] eop,
                                input logic done, input logic typ, input logic good,
                                input logic [11:0] len, input logic err);
        vec_t v;
        v.vld = vld; v.din = din; v.code = code; v.pdat = pdat; v.sop = sop; v.eop = eop;
        v.done = done; v.typ = typ; v.good = good; v.len = len; v.err = err;
        return v;
    endfunction

    task automatic step(input logic vld, input logic [31:0] din);
        bus.valid_in = vld;
        bus.data_in  = din;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input vec_t e);
        logic [44:0] act, exp;
        act = {bus.valid_out, bus.code_out, bus.pkt_dat, bus.sop, bus.eop,
               bus.pkt_done, bus.pkt_type, bus.pkt_good, bus.pkt_len, bus.frame_err};
        exp = {e.vld, e.code, e.pdat, e.sop, e.eop, e.done, e.typ, e.good, e.len, e.err};
        n_vec++;
        if (act !== exp || (e.vld && bus.data_out !== e.din)) begin
            n_bad++;
            $display("FAIL %s: got {vo,code,pdat,sop,eop,done,typ,good,len,err}=%h dout=%h, want %h dout=%h",
                     nm, act, bus.data_out, exp, e.din);
        end
    endtask

    task automatic run_vec(input string nm, input vec_t v);
        step(v.vld, v.din);
        check(nm, v);
    endtask

    initial begin
        vec_t z;
        z = mk(0, 32'h0, 16'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 12'd0, 0);

        //        vld din           code     pdat     sop      eop      dn ty gd len    err
        tbl.push_back(mk(1, 32'h020100FB, 16'h0004, 4'b1110, 4'b0001, 4'b0000, 0, 0, 0, 12'd0, 0)); // STP
        tbl.push_back(mk(1, 32'hFD050403, 16'h6000, 4'b0111, 4'b0000, 4'b1000, 1, 0, 1, 12'd6, 0)); // END
        tbl.push_back(mk(1, 32'h0000005C, 16'h0005, 4'b1110, 4'b0001, 4'b0000, 0, 0, 0, 12'd0, 0)); // SDP
        tbl.push_back(mk(1, 32'hFE000000, 16'h7000, 4'b0111, 4'b0000, 4'b1000, 1, 1, 0, 12'd6, 0)); // EDB
        tbl.push_back(mk(1, 32'h000000FD, 16'h0006, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 12'd0, 1)); // END idle
        tbl.push_back(mk(1, 32'h2211FB1C, 16'h0043, 4'b1100, 4'b0010, 4'b0000, 0, 0, 0, 12'd0, 0)); // SKP,STP
        tbl.push_back(mk(1, 32'h7C3CF7BC, 16'h9821, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 12'd0, 1)); // COM abort
        tbl.push_back(mk(1, 32'h0000FD00, 16'h0060, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 12'd0, 1)); // stray END
        tbl.push_back(mk(0, 32'hFDFDFBFB, 16'h0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 12'd0, 0)); // idle beat
        tbl.push_back(mk(1, 32'hFB000000, 16'h4000, 4'b0000, 4'b1000, 4'b0000, 0, 0, 0, 12'd0, 0)); // STP lane3
        tbl.push_back(mk(0, 32'hFDFDFDFD, 16'h0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 12'd0, 0)); // gap 1
        tbl.push_back(mk(0, 32'hFEFEFEFE, 16'h0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 12'd0, 0)); // gap 2
        tbl.push_back(mk(0, 32'hBCBCBCBC, 16'h0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 12'd0, 0)); // gap 3
        tbl.push_back(mk(1, 32'h00FDBBAA, 16'h0600, 4'b0011, 4'b0000, 4'b0100, 1, 0, 1, 12'd2, 0)); // END gap
        tbl.push_back(mk(1, 32'h025C01FB, 16'h0504, 4'b1010, 4'b0101, 4'b0000, 0, 0, 0, 12'd0, 1)); // SDP restart
        tbl.push_back(mk(1, 32'h000000FE, 16'h0007, 4'b0000, 4'b0000, 4'b0001, 1, 1, 0, 12'd1, 0)); // EDB len1
        tbl.push_back(mk(1, 32'hFD02015C, 16'h6005, 4'b0110, 4'b0001, 4'b1000, 1, 1, 1, 12'd2, 0)); // same beat

        bus.valid_in = 1'b0;
        bus.data_in  = '0;
        reset        = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset_state", z);
        if (bus.data_out !== '0) begin
            n_bad++;
            $display("FAIL reset_dout: got %h, want 0", bus.data_out);
        end
        reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++)
            run_vec($sformatf("vec%0d", i), tbl[i]);

        // Reset in the middle of an open packet drops it.
        run_vec("rst_open", mk(1, 32'h000000FB, 16'h0004, 4'b1110, 4'b0001, 4'b0000, 0, 0, 0, 12'd0, 0));
        reset = 1'b1;
        step(1, 32'hFD000000);
        check("rst_mid", z);
        if (bus.data_out !== '0) begin
            n_bad++;
            $display("FAIL rst_mid_dout: got %h, want 0", bus.data_out);
        end
        reset = 1'b0;
        run_vec("rst_after_end", mk(1, 32'h000000FD, 16'h0006, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 12'd0, 1));

        // Length saturation: 3 + 1023*4 = 4095 data bytes, then more, then END.
        run_vec("sat_open", mk(1, 32'h000000FB, 16'h0004, 4'b1110, 4'b0001, 4'b0000, 0, 0, 0, 12'd0, 0));
        for (int i = 0; i < 1030; i++) step(1, 32'h0);
        check("sat_mid", mk(1, 32'h0, 16'h0, 4'b1111, 4'b0, 4'b0, 0, 0, 0, 12'd0, 0));
        run_vec("sat_end", mk(1, 32'h000000FD, 16'h0006, 4'b0000, 4'b0000, 4'b0001, 1, 0, 1, 12'd4095, 0));
        run_vec("sat_clear", mk(1, 32'hFD00FB00, 16'h6040, 4'b0100, 4'b0010, 4'b1000, 1, 0, 1, 12'd1, 0));

`ifdef FRAMER_STATS_EN
        reset = 1'b1;
        step(0, 32'h0);
        reset = 1'b0;
        n_vec++;
        if ({bus.cnt_good, bus.cnt_null, bus.cnt_err} !== 48'h0) begin
            n_bad++;
            $display("FAIL stats_reset: got %h %h %h, want 0 0 0", bus.cnt_good, bus.cnt_null, bus.cnt_err);
        end
        for (int k = 0; k < 2; k++) begin
            step(1, 32'h020100FB);
            step(1, 32'hFD050403);
        end
        step(1, 32'h0000005C);
        step(1, 32'hFE000000);
        for (int k = 0; k < 3; k++) step(1, 32'h000000FD);
        step(0, 32'h0);
        step(0, 32'h0);
        n_vec++;
        if (bus.cnt_good !== 16'd2 || bus.cnt_null !== 16'd1 || bus.cnt_err !== 16'd3) begin
            n_bad++;
            $display("FAIL stats_count: got good=%0d null=%0d err=%0d, want 2 1 3",
                     bus.cnt_good, bus.cnt_null, bus.cnt_err);
        end
        for (int k = 0; k < 65540; k++) step(1, 32'h000000FD);
        step(0, 32'h0);
        step(0, 32'h0);
        n_vec++;
        if (bus.cnt_err !== 16'hFFFF || bus.cnt_good !== 16'd2) begin
            n_bad++;
            $display("FAIL stats_sat: got err=%h good=%0d, want FFFF 2", bus.cnt_err, bus.cnt_good);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
